// File: rtl/shf_seq.sv
// Multi-cycle shift/rotate unit: latches operand/mode/count on START and
// performs one single-bit step per clock, then pulses SHF_DONE for a cycle.
// Ports: CLK, RST (async, active-high); SHF_START, SHF_IN, SHF_TIMES,
// SHF_MODE, SHF_CF_IN in; SHF_BUSY, SHF_DONE, SHF_OUT, SHF_CF_OUT, SHF_ZF,
// SHF_SF, SHF_OVF out. Define SHF_SEQ_OVF_EN for the sticky SAL overflow bit.
module shf_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SHF_START,
  input  logic [WIDTH-1:0] SHF_IN,
  input  logic [CNT_W-1:0] SHF_TIMES,
  input  logic [3:0]       SHF_MODE,
  input  logic             SHF_CF_IN,
  output logic             SHF_BUSY,
  output logic             SHF_DONE,
  output logic [WIDTH-1:0] SHF_OUT,
  output logic             SHF_CF_OUT,
  output logic             SHF_ZF,
  output logic             SHF_SF,
  output logic             SHF_OVF
);

  localparam logic [3:0] M_SHL = 4'b0000;
  localparam logic [3:0] M_SHR = 4'b0001;
  localparam logic [3:0] M_SCL = 4'b0010;
  localparam logic [3:0] M_SCR = 4'b0011;
  localparam logic [3:0] M_SAL = 4'b0100;
  localparam logic [3:0] M_SAR = 4'b0101;
  localparam logic [3:0] M_ROL = 4'b0110;
  localparam logic [3:0] M_ROR = 4'b0111;
  localparam logic [3:0] M_RCL = 4'b1000;
  localparam logic [3:0] M_RCR = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_d;
  logic             step_c;
  logic             accept;

  // START is only looked at when no operation is in flight.
  assign accept = SHF_START && (state_q != SHIFT);

  always_comb begin
    step_d = d_q;
    step_c = c_q;
    case (mode_q)
      M_SHL: step_d = {d_q[WIDTH-2:0], 1'b0};
      M_SHR: step_d = {1'b0, d_q[WIDTH-1:1]};
      M_SCL: begin
        step_c = d_q[WIDTH-1];
        step_d = {d_q[WIDTH-2:0], 1'b0};
      end
      M_SCR: begin
        step_d = {c_q, d_q[WIDTH-1:1]};
        step_c = 1'b0;
      end
      M_SAL: begin
        step_c = d_q[WIDTH-1];
        step_d = {d_q[WIDTH-2:0], 1'b0};
      end
      M_SAR: begin
        step_c = d_q[0];
        step_d = {d_q[WIDTH-1], d_q[WIDTH-1:1]};
      end
      M_ROL: step_d = {d_q[WIDTH-2:0], d_q[WIDTH-1]};
      M_ROR: step_d = {d_q[0], d_q[WIDTH-1:1]};
      M_RCL: begin
        step_d = {d_q[WIDTH-2:0], c_q};
        step_c = d_q[WIDTH-1];
      end
      M_RCR: begin
        step_d = {c_q, d_q[WIDTH-1:1]};
        step_c = d_q[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      SHIFT: begin
        d_d   = step_d;
        c_d   = step_c;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      IDLE, DONE: begin
        if (accept) begin
          d_d    = SHF_IN;
          c_d    = SHF_CF_IN;
          cnt_d  = SHF_TIMES;
          mode_d = SHF_MODE;
          // Zero count and reserved modes complete as a pass-through.
          if (SHF_TIMES == '0 || SHF_MODE > M_RCR) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SHIFT;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      d_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SHF_SEQ_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky: any SAL step that changes the sign bit flags overflow.
  always_comb begin
    ovf_d = ovf_q;
    if (accept) begin
      ovf_d = 1'b0;
    end else if (state_q == SHIFT && mode_q == M_SAL &&
                 d_q[WIDTH-1] != d_q[WIDTH-2]) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign SHF_OVF = ovf_q;
`else
  assign SHF_OVF = 1'b0;
`endif

  assign SHF_BUSY   = busy_q;
  assign SHF_DONE   = done_q;
  assign SHF_OUT    = d_q;
  assign SHF_CF_OUT = c_q;
  assign SHF_ZF     = (d_q == '0);
  assign SHF_SF     = d_q[WIDTH-1];

endmodule

// File: tb/tb_shf_seq.sv
// Scoreboard bench for shf_seq: the driver queues expected results at
// each accepted START; a negedge monitor checks every SHF_DONE pulse.
module tb_shf_seq;

  localparam int W  = 16;
  localparam int CW = 4;

  localparam logic [3:0] SHL = 4'h0;
  localparam logic [3:0] SHR = 4'h1;
  localparam logic [3:0] SCL = 4'h2;
  localparam logic [3:0] SCR = 4'h3;
  localparam logic [3:0] SAL = 4'h4;
  localparam logic [3:0] SAR = 4'h5;
  localparam logic [3:0] ROL = 4'h6;
  localparam logic [3:0] ROR = 4'h7;
  localparam logic [3:0] RCL = 4'h8;
  localparam logic [3:0] RCR = 4'h9;
  localparam logic [3:0] RSV = 4'hC;

  logic          CLK = 1'b0;
  logic          RST;
  logic          SHF_START;
  logic [W-1:0]  SHF_IN;
  logic [CW-1:0] SHF_TIMES;
  logic [3:0]    SHF_MODE;
  logic          SHF_CF_IN;
  logic          SHF_BUSY;
  logic          SHF_DONE;
  logic [W-1:0]  SHF_OUT;
  logic          SHF_CF_OUT;
  logic          SHF_ZF;
  logic          SHF_SF;
  logic          SHF_OVF;

  shf_seq #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SHF_START (SHF_START),
    .SHF_IN    (SHF_IN),
    .SHF_TIMES (SHF_TIMES),
    .SHF_MODE  (SHF_MODE),
    .SHF_CF_IN (SHF_CF_IN),
    .SHF_BUSY  (SHF_BUSY),
    .SHF_DONE  (SHF_DONE),
    .SHF_OUT   (SHF_OUT),
    .SHF_CF_OUT(SHF_CF_OUT),
    .SHF_ZF    (SHF_ZF),
    .SHF_SF    (SHF_SF),
    .SHF_OVF   (SHF_OVF)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic [W-1:0] out;
    logic         cf;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endfunction

  exp_t me;
  always @(negedge CLK) begin
    if (!RST) begin
      if (SHF_DONE) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          me = sb.pop_front();
          chk({me.name, "_out"}, SHF_OUT, me.out);
          chk({me.name, "_cf"}, SHF_CF_OUT, me.cf);
          chk({me.name, "_zf"}, SHF_ZF, me.out == '0);
          chk({me.name, "_sf"}, SHF_SF, me.out[W-1]);
          chk({me.name, "_ovf"}, SHF_OVF, me.ovf);
          chk({me.name, "_cycle"}, cyc, me.cyc);
        end
      end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
        me = sb.pop_front();
        chk({me.name, "_missing_done"}, 32'd0, 32'd1);
      end
    end
  end

  task automatic issue(string nm, logic [3:0] m, logic [W-1:0] in,
                       int n, logic cf, logic [W-1:0] eo, logic ec,
                       logic eovf, bit push);
    int   g;
    bit   sh;
    exp_t e;
    g = 0;
    while (SHF_BUSY && g < 200) begin
      @(posedge CLK);
      #1;
      g++;
    end
    if (SHF_BUSY) chk({nm, "_busy_timeout"}, 32'd1, 32'd0);
    SHF_START = 1'b1;
    SHF_MODE  = m;
    SHF_IN    = in;
    SHF_TIMES = CW'(n);
    SHF_CF_IN = cf;
    @(posedge CLK);
    #1;
    SHF_START = 1'b0;
    sh = (n != 0) && (m <= RCR);
    chk({nm, "_busy"}, SHF_BUSY, sh);
    if (push) begin
      e.name = nm;
      e.out  = eo;
      e.cf   = ec;
`ifdef SHF_SEQ_OVF_EN
      e.ovf  = eovf;
`else
      e.ovf  = 1'b0;
`endif
      e.cyc  = cyc + (sh ? n : 0);
      sb.push_back(e);
    end
  endtask

  initial begin
    int g;
    RST       = 1'b1;
    SHF_START = 1'b0;
    SHF_IN    = '0;
    SHF_TIMES = '0;
    SHF_MODE  = '0;
    SHF_CF_IN = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("rst_out", SHF_OUT, 16'h0000);
    chk("rst_cf", SHF_CF_OUT, 1'b0);
    chk("rst_zf", SHF_ZF, 1'b1);
    chk("rst_sf", SHF_SF, 1'b0);
    chk("rst_busy", SHF_BUSY, 1'b0);
    chk("rst_done", SHF_DONE, 1'b0);
    chk("rst_ovf", SHF_OVF, 1'b0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    issue("shl1",  SHL, 16'h8001, 1,  1'b1, 16'h0002, 1'b1, 1'b0, 1);
    issue("rcl2",  RCL, 16'h8000, 2,  1'b0, 16'h0001, 1'b0, 1'b0, 1);
    @(posedge CLK);
    #1;
    chk("rcl2_mid_d", SHF_OUT, 16'h0000);
    chk("rcl2_mid_c", SHF_CF_OUT, 1'b1);
    issue("sar15", SAR, 16'h8000, 15, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1);
    issue("sal1",  SAL, 16'h4000, 1,  1'b0, 16'h8000, 1'b0, 1'b1, 1);
    issue("salclr",SAL, 16'h0001, 1,  1'b1, 16'h0002, 1'b0, 1'b0, 1);
    issue("ror0",  ROR, 16'h1234, 0,  1'b1, 16'h1234, 1'b1, 1'b0, 1);
    issue("shr5",  SHR, 16'h00F0, 5,  1'b0, 16'h0007, 1'b0, 1'b0, 1);
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    SHF_START = 1'b1;
    SHF_MODE  = ROL;
    SHF_IN    = 16'hFFFF;
    SHF_TIMES = 4'd1;
    SHF_CF_IN = 1'b1;
    @(posedge CLK);
    #1;
    SHF_START = 1'b0;
    chk("shr5_still_busy", SHF_BUSY, 1'b1);
    issue("scl1",  SCL, 16'hC000, 1,  1'b0, 16'h8000, 1'b1, 1'b0, 1);
    issue("scr2",  SCR, 16'h0003, 2,  1'b1, 16'h4000, 1'b0, 1'b0, 1);
    issue("rol4",  ROL, 16'h8421, 4,  1'b1, 16'h4218, 1'b1, 1'b0, 1);
    issue("rcr1",  RCR, 16'h0001, 1,  1'b0, 16'h0000, 1'b1, 1'b0, 1);
    issue("sal2",  SAL, 16'h2000, 2,  1'b0, 16'h8000, 1'b0, 1'b1, 1);
    repeat (4) begin
      @(posedge CLK);
      #1;
    end
    issue("rsv",   RSV, 16'hABCD, 7,  1'b1, 16'hABCD, 1'b1, 1'b0, 1);

    issue("shl8",  SHL, 16'h00FF, 8,  1'b0, 16'h0000, 1'b0, 1'b0, 0);
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    RST = 1'b1;
    #1;
    chk("abort_busy", SHF_BUSY, 1'b0);
    chk("abort_out", SHF_OUT, 16'h0000);
    chk("abort_zf", SHF_ZF, 1'b1);
    chk("abort_done", SHF_DONE, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (10) begin
      @(posedge CLK);
      #1;
    end
    issue("shr4",  SHR, 16'h0010, 4,  1'b0, 16'h0001, 1'b0, 1'b0, 1);

    g = 0;
    while (sb.size() != 0 && g < 300) begin
      @(posedge CLK);
      g++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shf_seq.md
# shf_seq

Parametrised multi-cycle shift/rotate unit for the controller datapath; next generation of the combinational shifter. It latches an operand, mode and count on a start handshake, then performs one single-bit step per clock. Carry, zero, sign and optional overflow are produced alongside the result. It sits between the register file and the flag register, and the sequencer waits on `SHF_DONE`.

## Interface
- `WIDTH`, default 16: data width; must be ≥4.
- `CNT_W`, default 4: count width, equal to `$clog2(WIDTH)`; counts run 0..WIDTH-1.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `SHF_START`  in  1  request; sampled only when `SHF_BUSY`=0.
- `SHF_IN`  in  WIDTH  operand.
- `SHF_TIMES`  in  CNT_W  step count n.
- `SHF_MODE`  in  4  operation select.
- `SHF_CF_IN`  in  1  carry-in.
- `SHF_BUSY`  out  1  high while in SHIFT.
- `SHF_DONE`  out  1  one-cycle result-valid pulse.
- `SHF_OUT`  out  WIDTH  result register D.
- `SHF_CF_OUT`  out  1  carry register C.
- `SHF_ZF`  out  1  (D == 0).
- `SHF_SF`  out  1  D[WIDTH-1].
- `SHF_OVF`  out  1  sticky arithmetic overflow.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- In IDLE or DONE with `SHF_START`=1, the block latches inputs: D←`SHF_IN`, C←`SHF_CF_IN`, count←n, mode latched, OVF←0.
  - If n=0 or the mode is reserved, it goes to DONE.
  - Otherwise it goes to SHIFT.
- In SHIFT, each edge performs one step and decrements the count. The edge where the count equals 1 goes to DONE.
- From DONE, the FSM goes to IDLE unless a new START is accepted.
- `SHF_START` is ignored while in SHIFT. Inputs are not re-sampled mid-operation.
- Per-step rules (W=WIDTH):
  - 0000 SHL: D←{D[W-2:0],0}; C held.
  - 0001 SHR: D←{0,D[W-1:1]}; C held.
  - 0010 SCL: C←D[W-1]; D←{D[W-2:0],0}.
  - 0011 SCR: D←{C,D[W-1:1]}; C←0.
  - 0100 SAL: C←D[W-1]; D←{D[W-2:0],0}; OVF set if D[W-1]≠D[W-2].
  - 0101 SAR: C←D[0]; D←{D[W-1],D[W-1:1]}.
  - 0110 ROL: D←{D[W-2:0],D[W-1]}; C held.
  - 0111 ROR: D←{D[0],D[W-1:1]}; C held.
  - 1000 RCL: D←{D[W-2:0],C}; C←D[W-1] (rotation through W+1 bits).
  - 1001 RCR: D←{C,D[W-1:1]}; C←D[0].
  - 1010–1111 reserved: behaves as n=0 (pass-through, C=`SHF_CF_IN`).
- Outputs hold their value after DONE until the next accepted START.

## Timing
- Let E be the edge that samples START.
- `SHF_DONE` is high for exactly one cycle, following edge E+n (n=0 means following E). Total latency is n+1 cycles, counting the START cycle.
- `SHF_BUSY` is high from after E until edge E+n, when n≥1.
- START during the DONE cycle is accepted, giving back-to-back operations. The previous result is visible only during that DONE cycle.
- `SHF_ZF` and `SHF_SF` are derived combinationally from D. `SHF_OUT` and `SHF_CF_OUT` are registered.
- Reset values: state IDLE, D=0, C=0, OVF=0, `SHF_BUSY`=0, `SHF_DONE`=0, `SHF_ZF`=1, `SHF_SF`=0.
- Reset asserted mid-SHIFT aborts immediately: no DONE is produced and all registers take their reset values.

## Configuration
- `SHF_SEQ_OVF_EN` defined: `SHF_OVF` is implemented as a sticky bit. It is cleared on START and set by any SAL step where D[W-1]≠D[W-2].
- Undefined: no OVF register; `SHF_OVF` is tied to 0. All other behaviour is identical.

## Test plan
- SHL, IN=0x8001, n=1, CF_IN=1 → OUT=0x0002, CF_OUT=1, DONE after E+1, BUSY high one cycle.
- RCL, IN=0x8000, CF_IN=0, n=2 → OUT=0x0001, CF_OUT=0, DONE after E+2; the intermediate step gives D=0x0000, C=1.
- SAR, IN=0x8000, n=15 → OUT=0xFFFF, CF_OUT=0, SF=1, ZF=0, DONE after E+15.
- SAL, IN=0x4000, n=1 → OUT=0x8000, CF_OUT=0. With `SHF_SEQ_OVF_EN`, OVF=1; without it, OVF=0.
- ROR, IN=0x1234, CF_IN=1, n=0 → DONE after E, OUT=0x1234, CF_OUT=1. A START pulsed during a later n=5 SHIFT is ignored, and that operation completes unaltered.
- Reset asserted on the third SHIFT cycle of SHL n=8 → immediately BUSY=0, OUT=0, ZF=1, and no DONE. A subsequent START with SHR, IN=0x0010, n=4 → OUT=0x0001.
